// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with op decode, registered result and iterative MUL/DIVU/REMU
//   clk, reset                : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready       : operation handshake; in_ready is high while idle
//   alu_op, funct3, funct7_5, funct7_0 : decode inputs from the ID/EX register
//   operand_a, operand_b      : rs1 and rs2/immediate
//   flush                     : kills a presented or iterating op
//   out_valid                 : one-cycle result strobe
//   result, zero, operation   : registered result, result==0 flag and decoded op
//   busy                      : multi-cycle op iterating
module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      operation,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic {IDLE, ITER} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_cnt;
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_result;
    logic [3:0]      r_mop;
    logic [3:0]      r_op;
    logic            r_valid;
    logic            r_zero;

    logic [3:0]      w_op;
    logic            w_r_alt;
    logic [SW-1:0]   w_shamt;
    logic [XLEN-1:0] w_res;
    logic            w_multi;
    logic            w_fire;
    logic            w_is_mul;
    logic [XLEN-1:0] w_mul_acc;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_iter_res;

    // R-type with bit 30 set is only legal for SUB and SRA; everything else falls back to ADD
    assign w_r_alt = !alu_op[0] && funct7_5;
    assign w_shamt = operand_b[SW-1:0];

    always_comb begin
        w_op = OP_ADD;
        if (alu_op == 2'b01)
            w_op = OP_SUB;
        else if (alu_op == 2'b10 && MUL_EN && funct7_0)
            w_op = funct7_5 ? OP_ADD :
                   funct3 == 3'b000 ? OP_MUL :
                   funct3 == 3'b101 ? OP_DIVU :
                   funct3 == 3'b111 ? OP_REMU : OP_ADD;
        else if (alu_op[1] && !(w_r_alt && funct3 != 3'b000 && funct3 != 3'b101))
            case (funct3)
                3'b000: w_op = w_r_alt ? OP_SUB : OP_ADD;
                3'b001: w_op = OP_SLL;
                3'b010: w_op = OP_SLT;
                3'b011: w_op = OP_SLTU;
                3'b100: w_op = OP_XOR;
                3'b101: w_op = funct7_5 ? OP_SRA : OP_SRL;
                3'b110: w_op = OP_OR;
                3'b111: w_op = OP_AND;
            endcase
    end

    // DIVU/REMU only reach this path with a zero divisor
    always_comb begin
        w_res = operand_a + operand_b;
        case (w_op)
            OP_SUB:  w_res = operand_a - operand_b;
            OP_AND:  w_res = operand_a & operand_b;
            OP_OR:   w_res = operand_a | operand_b;
            OP_XOR:  w_res = operand_a ^ operand_b;
            OP_SLL:  w_res = operand_a << w_shamt;
            OP_SRL:  w_res = operand_a >> w_shamt;
            OP_SRA:  w_res = $signed(operand_a) >>> w_shamt;
            OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: w_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            OP_DIVU: w_res = '1;
            OP_REMU: w_res = operand_a;
            default: ;
        endcase
    end

    assign w_multi = (w_op == OP_MUL) || ((w_op == OP_DIVU || w_op == OP_REMU) && operand_b != '0);
    assign w_fire  = in_valid && in_ready && !flush;

    // MUL: r_x = shifted multiplicand, r_y = shifted multiplier, r_acc = partial product
    // DIV: r_x = dividend shifting out / quotient shifting in, r_y = divisor, r_acc = remainder
    assign w_is_mul   = r_mop == OP_MUL;
    assign w_mul_acc  = r_acc + (r_y[0] ? r_x : '0);
    assign w_rem_sh   = {r_acc, r_x[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_y};
    assign w_rem_nx   = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nx   = {r_x[XLEN-2:0], !w_diff[XLEN]};
    assign w_iter_res = w_is_mul ? w_mul_acc : r_mop == OP_DIVU ? w_quo_nx : w_rem_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_mop    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_op     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_fire && w_multi) begin
                    r_state <= ITER;
                    r_cnt   <= '0;
                    r_x     <= operand_a;
                    r_y     <= operand_b;
                    r_acc   <= '0;
                    r_mop   <= w_op;
                end else if (w_fire) begin
                    r_valid  <= 1'b1;
                    r_result <= w_res;
                    r_zero   <= w_res == '0;
                    r_op     <= w_op;
                end
            end else if (flush) begin
                r_state <= IDLE;
            end else begin
                r_x   <= w_is_mul ? r_x << 1 : w_quo_nx;
                r_y   <= w_is_mul ? r_y >> 1 : r_y;
                r_acc <= w_is_mul ? w_mul_acc : w_rem_nx;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == SW'(XLEN-1)) begin
                    r_state  <= IDLE;
                    r_valid  <= 1'b1;
                    r_result <= w_iter_res;
                    r_zero   <= w_iter_res == '0;
                    r_op     <= r_mop;
                end
            end
        end
    end

    assign in_ready  = r_state == IDLE;
    assign busy      = r_state == ITER;
    assign out_valid = r_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign operation = r_op;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench with an arithmetic reference model and scoreboard
module tb_alu_exec_unit;
    localparam logic [3:0] M_AND = 4'd0, M_OR = 4'd1, M_ADD = 4'd2, M_XOR = 4'd3, M_SLL = 4'd4;
    localparam logic [3:0] M_SRL = 4'd5, M_SUB = 4'd6, M_SLT = 4'd7, M_SRA = 4'd8, M_SLTU = 4'd9;
    localparam logic [3:0] M_MUL = 4'd10, M_DIVU = 4'd11, M_REMU = 4'd12;
    localparam int NV = 28;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, flush = 1'b0, funct7_5 = 1'b0, funct7_0 = 1'b0;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;
    logic [3:0]  operation;

    logic        m0_in_valid = 1'b0, m0_funct7_5 = 1'b0, m0_funct7_0 = 1'b0;
    logic [1:0]  m0_alu_op = '0;
    logic [2:0]  m0_funct3 = '0;
    logic [31:0] m0_a = '0, m0_b = '0;
    logic        m0_in_ready, m0_out_valid, m0_zero, m0_busy;
    logic [31:0] m0_result;
    logic [3:0]  m0_operation;

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .out_valid(out_valid), .result(result), .zero(zero), .operation(operation), .busy(busy)
    );

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
        .alu_op(m0_alu_op), .funct3(m0_funct3), .funct7_5(m0_funct7_5), .funct7_0(m0_funct7_0),
        .operand_a(m0_a), .operand_b(m0_b), .flush(1'b0),
        .out_valid(m0_out_valid), .result(m0_result), .zero(m0_zero), .operation(m0_operation), .busy(m0_busy)
    );

    typedef struct {logic [31:0] res; logic [3:0] op; int due;} exp_t;
    typedef struct {logic [1:0] aop; logic [2:0] f3; logic f75; logic f70; logic [31:0] a; logic [31:0] b;} vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    vec_t tbl [NV] = '{
        '{2'd0, 3'd2, 1'b0, 1'b0, 32'h10, 32'hFFFFFFF0},
        '{2'd1, 3'd0, 1'b0, 1'b0, 32'd7, 32'd7},
        '{2'd2, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2},
        '{2'd2, 3'd1, 1'b0, 1'b0, 32'd1, 32'd35},
        '{2'd2, 3'd2, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd1},
        '{2'd2, 3'd3, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd1},
        '{2'd2, 3'd4, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00},
        '{2'd2, 3'd5, 1'b0, 1'b0, 32'h80000000, 32'd31},
        '{2'd2, 3'd5, 1'b1, 1'b0, 32'h80000000, 32'd31},
        '{2'd2, 3'd6, 1'b0, 1'b0, 32'h0F00, 32'h00F0},
        '{2'd2, 3'd7, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0},
        '{2'd2, 3'd1, 1'b1, 1'b0, 32'd3, 32'd4},
        '{2'd2, 3'd2, 1'b0, 1'b1, 32'd5, 32'd6},
        '{2'd2, 3'd0, 1'b1, 1'b1, 32'd5, 32'd6},
        '{2'd3, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7},
        '{2'd3, 3'd1, 1'b1, 1'b0, 32'd1, 32'd4},
        '{2'd3, 3'd2, 1'b0, 1'b0, 32'd5, 32'hFFFFFFFF},
        '{2'd3, 3'd4, 1'b0, 1'b0, 32'hAAAA, 32'hFFFF},
        '{2'd3, 3'd5, 1'b0, 1'b0, 32'hF0000000, 32'd4},
        '{2'd3, 3'd7, 1'b0, 1'b0, 32'h1234, 32'hFF},
        '{2'd3, 3'd0, 1'b0, 1'b1, 32'd3, 32'd4},
        '{2'd2, 3'd0, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0},
        '{2'd2, 3'd0, 1'b0, 1'b1, 32'd0, 32'd5},
        '{2'd2, 3'd5, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1},
        '{2'd2, 3'd5, 1'b0, 1'b1, 32'd5, 32'd7},
        '{2'd2, 3'd7, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd10},
        '{2'd2, 3'd7, 1'b0, 1'b1, 32'd7, 32'd7},
        '{2'd2, 3'd5, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF}
    };

    // Reference: returns {op, result}; MUL/DIV use the language's own * / %
    function automatic logic [35:0] model(input logic [1:0] aop, input logic [2:0] f3,
                                          input logic f75, input logic f70, input logic men,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  base [8];
        logic [3:0]  op;
        logic [31:0] r;
        base = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
        if (aop == 2'd0) op = M_ADD;
        else if (aop == 2'd1) op = M_SUB;
        else if (aop == 2'd2 && men && f70)
            op = f75 ? M_ADD : (f3 == 3'd0) ? M_MUL : (f3 == 3'd5) ? M_DIVU : (f3 == 3'd7) ? M_REMU : M_ADD;
        else if (f75 && f3 == 3'd5) op = M_SRA;
        else if (f75 && aop == 2'd2) op = (f3 == 3'd0) ? M_SUB : M_ADD;
        else op = base[f3];
        case (op)
            M_SUB:  r = a - b;
            M_AND:  r = a & b;
            M_OR:   r = a | b;
            M_XOR:  r = a ^ b;
            M_SLL:  r = a << b[4:0];
            M_SRL:  r = a >> b[4:0];
            M_SRA:  r = $signed(a) >>> b[4:0];
            M_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            M_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            M_MUL:  r = a * b;
            M_DIVU: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            M_REMU: r = (b == 0) ? a : a % b;
            default: r = a + b;
        endcase
        return {op, r};
    endfunction

    task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Every wait goes through here so the scoreboard sees each cycle
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (out_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_spurious cyc=%0d res=%h op=%b", cyc, result, operation);
            end else begin
                e = sb.pop_front();
                if (cyc != e.due || result !== e.res || operation !== e.op || zero !== (e.res == 32'd0)) begin
                    n_err++;
                    $display("FAIL sb_result cyc=%0d res=%h op=%b zero=%b, expected cyc=%0d res=%h op=%b zero=%b",
                             cyc, result, operation, zero, e.due, e.res, e.op, e.res == 32'd0);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_missing cyc=%0d no out_valid, expected res=%h op=%b", cyc, sb[0].res, sb[0].op);
            void'(sb.pop_front());
        end
    endtask

    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic f75, input logic f70,
                         input logic [31:0] a, input logic [31:0] b);
        logic [35:0] m;
        int g = 0;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout in_ready=%b expected=1", in_ready);
        end
        alu_op = aop; funct3 = f3; funct7_5 = f75; funct7_0 = f70; operand_a = a; operand_b = b;
        in_valid = 1'b1;
        m = model(aop, f3, f75, f70, 1'b1, a, b);
        sb.push_back('{m[31:0], m[35:32],
            cyc + 1 + ((m[35:32] == M_MUL || ((m[35:32] == M_DIVU || m[35:32] == M_REMU) && b != 0)) ? 32 : 0)});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!out_valid && g < 100) begin
            tick();
            g++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        in_valid = 1'b1; alu_op = 2'd2; operand_a = 32'd9; operand_b = 32'd9;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_operation", operation, 0);
        chk("rst_zero", zero, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("no_accept_in_reset", out_valid, 0);

        chk("pin_sub", model(2'd2, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7), {M_SUB, 32'hFFFFFFFE});
        chk("pin_srai", model(2'd3, 3'd5, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'd4), {M_SRA, 32'hF8000000});
        chk("pin_mul", model(2'd2, 3'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd3), {M_MUL, 32'hFFFFFFFD});
        chk("pin_divu", model(2'd2, 3'd5, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7), {M_DIVU, 32'd14});
        chk("pin_remu", model(2'd2, 3'd7, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7), {M_REMU, 32'd2});
        chk("pin_divu0", model(2'd2, 3'd5, 1'b0, 1'b1, 1'b1, 32'd100, 32'd0), {M_DIVU, 32'hFFFFFFFF});
        chk("pin_noM", model(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4), {M_ADD, 32'd7});
        chk("pin_unlisted", model(2'd2, 3'd1, 1'b1, 1'b0, 1'b1, 32'd3, 32'd4), {M_ADD, 32'd7});

        issue(2'd2, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7);
        chk("sub_result", result, 32'hFFFFFFFE);
        chk("sub_operation", operation, M_SUB);
        chk("sub_zero", zero, 0);

        issue(2'd3, 3'd5, 1'b1, 1'b0, 32'h80000000, 32'd4);
        chk("srai_result", result, 32'hF8000000);
        issue(2'd3, 3'd3, 1'b0, 1'b0, 32'd1, 32'd2);
        chk("sltiu_result", result, 32'd1);
        issue(2'd3, 3'd6, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("ori_result", result, 32'd0);
        chk("ori_zero", zero, 1);

        issue(2'd2, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3);
        chk("mul_busy", busy, 1);
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("mul_stall_cycles", n, 32);
        chk("mul_out_valid", out_valid, 1);
        chk("mul_result", result, 32'hFFFFFFFD);

        issue(2'd2, 3'd5, 1'b0, 1'b1, 32'd100, 32'd7);
        wait_done();
        chk("divu_result", result, 32'd14);
        issue(2'd2, 3'd7, 1'b0, 1'b1, 32'd100, 32'd7);
        wait_done();
        chk("remu_result", result, 32'd2);
        issue(2'd2, 3'd5, 1'b0, 1'b1, 32'd100, 32'd0);
        chk("divu0_valid", out_valid, 1);
        chk("divu0_result", result, 32'hFFFFFFFF);
        issue(2'd2, 3'd7, 1'b0, 1'b1, 32'd100, 32'd0);
        chk("remu0_result", result, 32'd100);

        issue(2'd2, 3'd5, 1'b0, 1'b1, 32'd1000, 32'd3);
        repeat (10) tick();
        flush = 1'b1;
        void'(sb.pop_back());
        tick();
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_busy", busy, 0);
        chk("flush_no_valid", out_valid, 0);
        issue(2'd0, 3'd0, 1'b0, 1'b0, 32'd123, 32'd456);
        chk("post_flush_add", result, 32'd579);

        alu_op = 2'd0; operand_a = 32'd1; operand_b = 32'd1;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        chk("idle_flush_no_valid", out_valid, 0);
        chk("idle_flush_hold", result, 32'd579);

        issue(2'd2, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7);
        repeat (5) tick();
        reset = 1'b1;
        void'(sb.pop_back());
        tick();
        reset = 1'b0;
        chk("iter_reset_no_valid", out_valid, 0);
        chk("iter_reset_ready", in_ready, 1);
        chk("iter_reset_result", result, 0);
        repeat (3) tick();

        for (int i = 0; i < NV; i++)
            issue(tbl[i].aop, tbl[i].f3, tbl[i].f75, tbl[i].f70, tbl[i].a, tbl[i].b);

        m0_alu_op = 2'd2; m0_funct3 = 3'd0; m0_funct7_0 = 1'b1; m0_a = 32'd3; m0_b = 32'd4;
        m0_in_valid = 1'b1;
        tick();
        m0_in_valid = 1'b0;
        chk("nom_valid", m0_out_valid, 1);
        chk("nom_add", {m0_operation, m0_result}, {M_ADD, 32'd7});
        chk("nom_model", {m0_operation, m0_result}, model(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4));
        m0_funct3 = 3'd5; m0_a = 32'h80; m0_b = 32'd4;
        m0_in_valid = 1'b1;
        tick();
        m0_in_valid = 1'b0;
        chk("nom_srl", {m0_operation, m0_result}, {M_SRL, 32'h8});
        chk("nom_ready", m0_in_ready, 1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised EX-stage execution unit for the pipelined RISC-V core. It merges ALU-control decode with a registered ALU datapath. It adds the full RV32I/RV64I integer op set plus iterative MUL/DIVU/REMU (M subset), with a valid/ready handshake that stalls the pipeline during multi-cycle ops. It sits between the ID/EX pipeline register and the EX/MEM register.

Parameters:
XLEN, 32, datapath width; must be 32 or 64.
MUL_EN, 1, 1 enables MUL/DIVU/REMU; 0 makes funct7_0 ignored (op decodes as its base-I op).

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operation presented this cycle
in_ready  output  1  unit can accept; equals (state==IDLE)
alu_op  input  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type ALU
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
funct7_0  input  1  instruction bit 25 (M-extension select, R-type only)
operand_a  input  XLEN  rs1 value
operand_b  input  XLEN  rs2 value or immediate
flush  input  1  kill in-flight/presented op (branch mispredict)
out_valid  output  1  one-cycle pulse, result valid
result  output  XLEN  registered result
zero  output  1  registered (result==0), aligned with result
operation  output  4  registered decoded op code, aligned with result
busy  output  1  multi-cycle op in progress (state==ITER)

Behaviour:
- Reset: state IDLE; out_valid, result, zero, operation, busy, and counter all 0; in_valid is ignored while reset is high.
- Accept: the handshake fires when in_valid & in_ready & !flush at a rising edge.
- Decode to operation:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 1000, SLT 0111, SLTU 1001, MUL 1010, DIVU 1011, REMU 1100.
  - alu_op 00 -> ADD.
  - alu_op 01 -> SUB.
  - alu_op 10 -> by funct3, funct7_5 selects SUB/SRA; funct7_0=1 (MUL_EN=1): funct3 000 MUL, 101 DIVU, 111 REMU.
  - alu_op 11 -> by funct3; funct7_5 is used only for SRAI; ADDI is never SUB.
  - Any unlisted combination -> ADD. Decode is fully specified, with no latched state.
- Arithmetic rules:
  - Shift amount is operand_b[log2(XLEN)-1:0].
  - SLT is signed; SLTU is unsigned.
  - Results are XLEN bits, wrap-around, no flags beyond zero.
  - MUL returns the low XLEN bits of the product.
- Single-cycle ops (including DIVU/REMU with operand_b==0): accepted at edge N -> out_valid=1 with result/zero/operation updated at edge N+1. in_ready stays 1, so back-to-back accepts occur every cycle.
- Divide by zero: DIVU -> all ones; REMU -> operand_a. No iteration.
- Multi-cycle ops (MUL, DIVU/REMU with nonzero divisor):
  - Edge N: accept, operands latched, counter=0, state->ITER.
  - In ITER: one shift-add (MUL) or restoring-subtract step (DIV) per cycle, counter+1.
  - On the cycle counter==XLEN-1, state->IDLE and out_valid=1, so the result appears at edge N+XLEN.
  - in_ready=0 and busy=1 throughout ITER.
- Flush:
  - In ITER: return to IDLE at the next edge; no out_valid; partial results discarded.
  - Coincident with in_valid in IDLE: the op is not accepted.
  - Does not retract an out_valid already registered.
- Reset in ITER: IDLE at the next edge; no out_valid.
- out_valid is high for exactly one cycle per accepted, unflushed op. result/zero/operation hold their value otherwise.

Test Plan:
- Reset held 2 cycles -> out_valid=0, result=0, in_ready=1; release and present alu_op=10, funct3=000, funct7_5=1, a=5, b=7 -> next cycle result=0xFFFFFFFE, operation=0110, zero=0.
- Back-to-back I-type: SRAI a=0x80000000 b=4, then SLTIU a=1 b=2, then ORI a=0 b=0 on consecutive cycles -> results 0xF8000000, 1, 0 (zero=1) on three consecutive cycles.
- MUL a=0xFFFFFFFF b=3 -> in_ready low 32 cycles, out_valid exactly 32 edges after accept, result=0xFFFFFFFD.
- DIVU a=100 b=7 -> result 14 after 32 cycles; REMU same operands -> 2; DIVU b=0 -> 0xFFFFFFFF after 1 cycle; REMU b=0 -> 100.
- Flush at ITER cycle 10 of DIVU -> no out_valid, in_ready=1 next cycle; new ADD accepted immediately returns the correct sum.
- MUL_EN=0, alu_op=10, funct3=000, funct7_0=1, a=3, b=4 -> ADD result 7 in 1 cycle; unlisted decode (alu_op=10, funct3=001, funct7_5=1) -> ADD.
